// File: rtl/wdog_sched.sv
// wdog_sched: four-slot watchdog scheduler.
// A tick starts a scan that visits one slot per cycle (slots 0..3). Each
// enabled slot counts down once per scan and latches a sticky expiry flag
// when its count runs out. Configuration and status use a simple
// single-cycle register bus.
//
// Bus handshake: an access happens in every cycle where stb is high. we
// selects a write (1) or a read (0). ack is stb itself, so the device never
// inserts wait states. Writes take effect at the next rising edge. Read data
// is combinational from the current register state, and data_out is zero
// in any cycle that is not a read.
module wdog_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        stb,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ack,
  output logic [3:0]  expired,
  output logic        trig
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  state_t      r_state;
  logic [1:0]  r_idx;
  logic        r_pending;
  logic        r_lost;
  logic [1:0]  r_sel;
  logic [15:0] r_timeout [4];
  logic [15:0] r_cnt     [4];
  logic [3:0]  r_en;
  logic [3:0]  r_exp;

  // Bus decode
  logic        w_wr;
  logic        w_rd;
  logic        w_wr_load;
  logic        w_wr_clear;
  logic        w_wr_sel;
  logic [1:0]  w_load_slot;
  logic [15:0] w_load_val;
  logic        w_scan;
  logic        w_busy;

  // Per-slot control
  logic [3:0]  w_load;
  logic [3:0]  w_proc;
  logic [3:0]  w_fire;
  logic [3:0]  w_clr;

  assign w_wr        = stb & we;
  assign w_rd        = stb & ~we;
  assign w_wr_load   = w_wr && (addr == 2'd0);
  assign w_wr_clear  = w_wr && (addr == 2'd1);
  assign w_wr_sel    = w_wr && (addr == 2'd2);
  assign w_load_slot = data_in[17:16];
  assign w_load_val  = data_in[15:0];
  assign w_scan      = (r_state == ST_SCAN);
  assign w_busy      = w_scan;

  // Per-slot strobes. A load to a slot wins over its scan in the same cycle.
  // An expiry wins over a same-cycle flag clear.
  always_comb begin
    w_load = '0;
    w_proc = '0;
    w_fire = '0;
    w_clr  = '0;
    for (int i = 0; i < 4; i++) begin
      w_load[i] = w_wr_load && (w_load_slot == 2'(i));
      w_proc[i] = w_scan && (r_idx == 2'(i)) && r_en[i] && !w_load[i];
      w_fire[i] = w_proc[i] && (r_cnt[i] == 16'd1);
      w_clr[i]  = w_wr_clear && data_in[i];
    end
  end

  // Slot state: timeout, countdown, enable and sticky expiry flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_timeout[i] <= '0;
        r_cnt[i]     <= '0;
      end
      r_en  <= '0;
      r_exp <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_load[i]) begin
          r_timeout[i] <= w_load_val;
          r_cnt[i]     <= w_load_val;
          r_en[i]      <= (w_load_val != 16'd0);
        end else if (w_fire[i]) begin
          r_cnt[i] <= 16'd0;
          r_en[i]  <= 1'b0;
        end else if (w_proc[i]) begin
          r_cnt[i] <= r_cnt[i] - 16'd1;
        end

        if (w_load[i]) begin
          r_exp[i] <= 1'b0;
        end else if (w_fire[i]) begin
          r_exp[i] <= 1'b1;
        end else if (w_clr[i]) begin
          r_exp[i] <= 1'b0;
        end
      end
    end
  end

  // Scan sequencer. One extra tick can be queued as pending during a scan.
  // A tick that arrives while one is already pending sets the sticky lost flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_idx     <= 2'd0;
      r_pending <= 1'b0;
      r_lost    <= 1'b0;
    end else begin
      // Clear comes first so that a dropped tick in the same cycle still sets lost
      if (w_wr_clear && data_in[8]) begin
        r_lost <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (tick) begin
            r_state <= ST_SCAN;
            r_idx   <= 2'd0;
          end
        end
        ST_SCAN: begin
          if (r_idx == 2'd3) begin
            // A tick on the last slot counts as pending and restarts at once
            if (r_pending || tick) begin
              r_state <= ST_SCAN;
              r_idx   <= 2'd0;
            end else begin
              r_state <= ST_IDLE;
              r_idx   <= 2'd0;
            end
            r_pending <= 1'b0;
            if (r_pending && tick) begin
              r_lost <= 1'b1;
            end
          end else begin
            r_idx <= r_idx + 2'd1;
            if (tick) begin
              if (r_pending) begin
                r_lost <= 1'b1;
              end else begin
                r_pending <= 1'b1;
              end
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_idx   <= 2'd0;
        end
      endcase
    end
  end

  // Read-slot select register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel <= 2'd0;
    end else if (w_wr_sel) begin
      r_sel <= data_in[1:0];
    end
  end

  // Read mux; zero in any cycle that is not a read
  always_comb begin
    data_out = 32'd0;
    if (w_rd) begin
      case (addr)
        2'd0:    data_out = {r_cnt[r_sel], r_timeout[r_sel]};
        2'd1:    data_out = {22'd0, w_busy, r_lost, r_en, r_exp};
        2'd2:    data_out = {30'd0, r_sel};
        default: data_out = 32'd0;
      endcase
    end
  end

  assign ack     = stb;
  assign expired = r_exp;
  assign trig    = |r_exp;

endmodule

// File: tb/tb_wdog_sched.sv
// Testbench for wdog_sched: register table, directed corner sequences and
// random traffic checked against a scan-queue reference model.
module tb_wdog_sched;

  logic        clk;
  logic        rst_n;
  logic        tick;
  logic        stb;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ack;
  logic [3:0]  expired;
  logic        trig;

  int checks = 0;
  int errors = 0;

  wdog_sched dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .stb      (stb),
    .we       (we),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .ack      (ack),
    .expired  (expired),
    .trig     (trig)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // The queue holds the slot numbers still to be visited, one per clock edge.
  // A tick queues a full scan (0..3) unless a second scan is already queued,
  // in which case the tick is lost.
  logic [15:0] m_timeout [4];
  logic [15:0] m_cnt     [4];
  logic [3:0]  m_en;
  logic [3:0]  m_exp;
  logic [1:0]  m_sel;
  logic        m_lost;
  int          scan_q[$];

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_timeout[i] = '0;
      m_cnt[i]     = '0;
    end
    m_en   = '0;
    m_exp  = '0;
    m_sel  = '0;
    m_lost = 1'b0;
    scan_q.delete();
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {m_cnt[m_sel], m_timeout[m_sel]};
      2'd1:    return {22'd0, (scan_q.size() != 0), m_lost, m_en, m_exp};
      2'd2:    return {30'd0, m_sel};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step(input logic t, input logic s, input logic w,
                            input logic [1:0] a, input logic [31:0] d);
    int   proc;
    logic set_lost;
    logic fire;
    logic is_load;
    int   slot;
    proc     = -1;
    set_lost = 1'b0;
    fire     = 1'b0;
    is_load  = s && w && (a == 2'd0);
    slot     = int'(d[17:16]);
    if (scan_q.size() == 0) begin
      if (t) for (int k = 0; k < 4; k++) scan_q.push_back(k);
    end else begin
      proc = scan_q.pop_front();
      if (t) begin
        if (scan_q.size() >= 4) set_lost = 1'b1;
        else for (int k = 0; k < 4; k++) scan_q.push_back(k);
      end
    end
    if (proc >= 0 && m_en[proc] && !(is_load && slot == proc)) begin
      if (m_cnt[proc] == 16'd1) begin
        m_cnt[proc] = 16'd0;
        m_en[proc]  = 1'b0;
        m_exp[proc] = 1'b1;
        fire        = 1'b1;
      end else begin
        m_cnt[proc] = m_cnt[proc] - 16'd1;
      end
    end
    if (is_load) begin
      m_timeout[slot] = d[15:0];
      m_cnt[slot]     = d[15:0];
      m_en[slot]      = (d[15:0] != 16'd0);
      m_exp[slot]     = 1'b0;
    end
    if (s && w && a == 2'd1) begin
      for (int k = 0; k < 4; k++)
        if (d[k] && !(fire && proc == k)) m_exp[k] = 1'b0;
      if (d[8]) m_lost = 1'b0;
    end
    if (set_lost) m_lost = 1'b1;
    if (s && w && a == 2'd2) m_sel = d[1:0];
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One bus cycle: drive on the falling edge, compare settled outputs against
  // the model, then advance the model on the rising edge. Returns at the edge.
  task automatic cycle(input logic t, input logic s, input logic w,
                       input logic [1:0] a, input logic [31:0] d,
                       output logic [31:0] dout);
    @(negedge clk);
    tick = t; stb = s; we = w; addr = a; data_in = d;
    #1;
    dout = data_out;
    chk("ack", {31'd0, ack}, {31'd0, s});
    chk("expired", {28'd0, expired}, {28'd0, m_exp});
    chk("trig", {31'd0, trig}, {31'd0, |m_exp});
    chk("data_out", data_out, (s && !w) ? model_read(a) : 32'd0);
    @(posedge clk);
    model_step(t, s, w, a, d);
  endtask

  logic [31:0] rd;

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, rd);
  endtask

  task automatic do_tick();
    cycle(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, rd);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cycle(1'b0, 1'b1, 1'b1, a, d, rd);
  endtask

  task automatic rdreg(input logic [1:0] a, output logic [31:0] v);
    cycle(1'b0, 1'b1, 1'b0, a, 32'd0, v);
  endtask

  // Check the flags just after the last rising edge
  task automatic peek(input string name, input logic [3:0] want);
    #2;
    chk(name, {28'd0, expired}, {28'd0, want});
    chk({name, "_trig"}, {31'd0, trig}, {31'd0, |want});
  endtask

  // Reset pulse, asserted between edges so it acts asynchronously
  task automatic pulse_reset();
    #2;
    rst_n = 1'b0;
    tick = 1'b0; stb = 1'b0; we = 1'b0; addr = 2'd0; data_in = 32'd0;
    #1;
    chk("rst_expired", {28'd0, expired}, 32'd0);
    chk("rst_trig", {31'd0, trig}, 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
  endtask

  // ---------------- register access table ----------------
  typedef struct {
    logic        s;
    logic        w;
    logic [1:0]  a;
    logic [31:0] d;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t vecs[16];

  initial begin
    rst_n = 1'b0;
    tick = 1'b0; stb = 1'b0; we = 1'b0; addr = 2'd0; data_in = 32'd0;
    model_reset();

    vecs[0]  = '{1'b1, 1'b0, 2'd2, 32'h0,         32'h0};
    vecs[1]  = '{1'b1, 1'b1, 2'd2, 32'h3,         32'h0};
    vecs[2]  = '{1'b1, 1'b0, 2'd2, 32'h0,         32'h3};
    vecs[3]  = '{1'b1, 1'b1, 2'd0, 32'h0001_1234, 32'h0};
    vecs[4]  = '{1'b1, 1'b1, 2'd2, 32'h1,         32'h0};
    vecs[5]  = '{1'b1, 1'b0, 2'd0, 32'h0,         32'h1234_1234};
    vecs[6]  = '{1'b1, 1'b0, 2'd1, 32'h0,         32'h20};
    vecs[7]  = '{1'b1, 1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 2'd3, 32'h0,         32'h0};
    vecs[9]  = '{1'b1, 1'b1, 2'd0, 32'h0003_0007, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 2'd1, 32'h0,         32'hA0};
    vecs[11] = '{1'b1, 1'b0, 2'd2, 32'h0,         32'h1};
    vecs[12] = '{1'b1, 1'b1, 2'd0, 32'h0001_0000, 32'h0};
    vecs[13] = '{1'b1, 1'b0, 2'd1, 32'h0,         32'h80};
    vecs[14] = '{1'b1, 1'b0, 2'd0, 32'h0,         32'h0};
    vecs[15] = '{1'b0, 1'b0, 2'd1, 32'h0,         32'h0};

    // Reset state
    #3;
    chk("reset_expired", {28'd0, expired}, 32'd0);
    chk("reset_trig", {31'd0, trig}, 32'd0);
    chk("reset_dout", data_out, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);

    // Table-driven register accesses
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, vecs[i].s, vecs[i].w, vecs[i].a, vecs[i].d, rd);
      chk($sformatf("vec%0d", i), rd, vecs[i].exp_dout);
    end

    // Slot 0 T=3 expires exactly one edge after its third visit
    pulse_reset();
    wr(2'd0, 32'h0000_0003);
    do_tick(); idle(9);
    do_tick(); idle(9);
    peek("t3_before", 4'b0000);
    do_tick();
    peek("t3_at_tick", 4'b0000);
    idle(1);
    peek("t3_expired", 4'b0001);

    // Slot 2: clear after expiry, then clear colliding with expiry
    pulse_reset();
    wr(2'd0, 32'h0002_0002);
    do_tick(); idle(5);
    do_tick(); idle(2);
    peek("s2_pre", 4'b0000);
    idle(1);
    peek("s2_expired", 4'b0100);
    wr(2'd1, 32'h4);
    peek("s2_cleared", 4'b0000);
    wr(2'd0, 32'h0002_0002);
    do_tick(); idle(5);
    do_tick(); idle(2);
    wr(2'd1, 32'h4);
    peek("s2_collide", 4'b0100);

    // Slot 1 reloaded every third tick never expires
    pulse_reset();
    wr(2'd2, 32'h1);
    wr(2'd0, 32'h0001_0005);
    for (int t = 1; t <= 20; t++) begin
      do_tick(); idle(5);
      if (t % 3 == 0) wr(2'd0, 32'h0001_0005);
      rdreg(2'd0, rd);
      checks++;
      if (rd[31:16] < 16'd3 || rd[31:16] > 16'd5) begin
        errors++;
        $display("FAIL reload_cnt got=%0d want=3..5", rd[31:16]);
      end
    end
    peek("reload_noexp", 4'b0000);

    // Back-to-back ticks: second pending, third lost
    pulse_reset();
    do_tick(); do_tick(); do_tick();
    idle(2);
    rdreg(2'd1, rd);
    chk("b2b_busy_lost", {30'd0, rd[9:8]}, 32'd3);
    idle(8);
    rdreg(2'd1, rd);
    chk("b2b_lost_idle", {30'd0, rd[9:8]}, 32'd1);
    wr(2'd1, 32'h100);
    rdreg(2'd1, rd);
    chk("b2b_lost_clr", rd, 32'd0);

    // Reset mid-scan aborts everything; later scan is clean
    pulse_reset();
    wr(2'd0, 32'h0003_FFFF);
    do_tick(); idle(1);
    pulse_reset();
    rdreg(2'd1, rd);
    chk("midrst_status", rd, 32'd0);
    rdreg(2'd0, rd);
    chk("midrst_slot", rd, 32'd0);
    rdreg(2'd2, rd);
    chk("midrst_sel", rd, 32'd0);
    do_tick(); idle(6);
    rdreg(2'd1, rd);
    chk("midrst_after", rd, 32'd0);
    peek("midrst_noexp", 4'b0000);

    // Loading 0 into a running slot disables it
    pulse_reset();
    wr(2'd0, 32'h0000_0002);
    do_tick(); idle(5);
    wr(2'd0, 32'h0000_0000);
    rdreg(2'd1, rd);
    chk("zero_status", rd, 32'd0);
    rdreg(2'd0, rd);
    chk("zero_slot", rd, 32'd0);
    do_tick(); idle(5);
    do_tick(); idle(5);
    peek("zero_noexp", 4'b0000);

    // Random traffic against the model
    pulse_reset();
    for (int n = 0; n < 3000; n++) begin
      logic        t;
      logic        s;
      logic        w;
      logic [1:0]  a;
      logic [31:0] d;
      t = ($urandom_range(0, 5) == 0);
      s = ($urandom_range(0, 2) == 0);
      w = $urandom_range(0, 1) == 1;
      a = 2'($urandom_range(0, 3));
      d = $urandom;
      if (a == 2'd0) d = {14'd0, d[17:16], 16'($urandom_range(0, 6))};
      if (a == 2'd1 && $urandom_range(0, 3) != 0) d[8] = 1'b0;
      cycle(t, s, w, a, d, rd);
      if ($urandom_range(0, 400) == 0) pulse_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wdog_sched.md
WDOG_SCHED -- requirements
Module: wdog_sched

Interface
REQ-001 Parameters: none; slot count fixed at 4, counter width fixed at 16.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  system clock; all state changes on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 tick  in  1  time base strobe, one clk wide, typically 1 ms.
REQ-006 stb  in  1  bus strobe for this device.
REQ-007 we  in  1  write enable, qualified by stb.
REQ-008 addr  in  2  register select.
REQ-009 data_in  in  32  write data.
REQ-010 data_out  out  32  read data; 32'b0 when not (stb & ~we).
REQ-011 ack  out  1  equals stb, combinational.
REQ-012 expired  out  4  per-slot sticky expiry flags.
REQ-013 trig  out  1  OR of expired[3:0].

Function
REQ-014 Per slot i (0..3): timeout[i] 16b, cnt[i] 16b, en[i], exp[i]; expired[i] = exp[i].
REQ-015 Write addr 0: slot = data_in[17:16], timeout[slot] and cnt[slot] <= data_in[15:0], en[slot] <= (data_in[15:0] != 0), exp[slot] <= 0.
REQ-016 Write addr 1: for each bit k set in data_in[3:0], exp[k] <= 0; data_in[8] = 1 clears lost.
REQ-017 Write addr 2: sel <= data_in[1:0]; write addr 3 ignored.
REQ-018 Read addr 0: {cnt[sel], timeout[sel]}; addr 1: {22'b0, busy, lost, en[3:0], exp[3:0]}; addr 2: {30'b0, sel}; addr 3: 0.
REQ-019 FSM states IDLE, SCAN; 2-bit index idx; busy = (state == SCAN).
REQ-020 IDLE and tick = 1: next state SCAN, idx <= 0.
REQ-021 SCAN: each cycle processes slot idx; idx increments; idx == 3 ends scan.
REQ-022 Processing slot i with en[i] = 1: cnt[i] == 1 -> cnt[i] <= 0, en[i] <= 0, exp[i] <= 1; otherwise cnt[i] <= cnt[i] - 1.
REQ-023 Processing slot i with en[i] = 0: no state change.
REQ-024 Slot loaded with value T expires on the T-th scan after the load; cnt never wraps below 0.
REQ-025 Same-cycle addr-0 write and scan of the same slot: write wins, no decrement that tick.
REQ-026 Same-cycle addr-1 clear and expiry of the same slot: expiry wins, exp stays 1.
REQ-027 tick during SCAN: pending <= 1; at end of scan (idx == 3), pending = 1 -> SCAN, idx <= 0, pending <= 0; else IDLE.
REQ-028 tick during SCAN with pending already 1: tick dropped, sticky lost <= 1.
REQ-029 tick on the last SCAN cycle (idx == 3) sets pending; tick is never silently lost.
REQ-030 Latency: tick sampled at edge N; slot i processed at edge N+1+i; exp/trig visible after edge N+1+i.

Reset
REQ-031 rst_n = 0 SHALL immediately clear timeout, cnt, en, exp, sel, pending, lost; state IDLE, idx 0.
REQ-032 Reset values: expired = 0, trig = 0, data_out = 0 when not reading, ack = stb.
REQ-033 Reset asserted mid-scan SHALL abort the scan; first tick after release starts a fresh scan at slot 0.

Verification
REQ-034 Write addr0 0x0000_0003 (slot 0, T=3); 3 ticks 10 cycles apart -> expired = 0001, trig = 1 one cycle after 3rd scan of slot 0; no change before.
REQ-035 Slot 2 T=2, write addr1 data 0x4 after expiry -> expired[2] = 0, trig = 0; same-cycle clear and expiry -> expired[2] stays 1.
REQ-036 Slot 1 T=5, reload T=5 every 3 ticks for 20 ticks -> expired[1] never set; readback sel=1 shows cnt in 3..5.
REQ-037 Ticks on back-to-back cycles (3 consecutive) -> second held as pending and scanned, third sets lost = 1 (status bit 8); write addr1 0x100 clears it.
REQ-038 Slot 3 T=0xFFFF, reset pulse mid-scan -> all status 0; post-reset tick scans cleanly with no expiry.
REQ-039 Write addr0 timeout 0 to a running slot -> en = 0, cnt = 0, no expiry on later ticks.
